// File: rtl/memory_stage_if.sv
// Data-memory request/acknowledge bus between the memory stage and the data memory.
//   master (stage side): drives req, we, addr, wdata, be; samples ack, rdata
//   slave  (memory side): samples req, we, addr, wdata, be; drives ack, rdata
// ack completes the current request in the cycle it is high; rdata is valid with ack.
interface memory_stage_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
);
  logic                    req;
  logic                    we;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] be;
  logic                    ack;
  logic [DATA_WIDTH-1:0]   rdata;

  modport master (output req, we, addr, wdata, be, input ack, rdata);
  modport slave  (input req, we, addr, wdata, be, output ack, rdata);
endinterface

// File: rtl/memory_stage.sv
// Memory-access pipeline stage (M) between the execute register and writeback.
// Converts load/store control into a req/ack data-memory transaction (byte enables,
// store lane shift, load extraction with sign/zero extension), owns the M->W register
// and stalls upstream while a transaction is outstanding.
// Ports:
//   i_clk, i_arst        clock (rising) / asynchronous active-low reset
//   i_result_src..i_rd_addr  execute-register fields (load = result_src 3'd1, store = mem_we)
//   dmem                 data-memory bus (master side)
//   o_stall_m            request outstanding and not acknowledged this cycle
//   o_misaligned         one-cycle pulse when a misaligned/illegal access is dropped
//   o_rd_addr_m, o_reg_we_m  combinational copies of rd/reg_we for the hazard unit
//   o_result_src..o_rd_addr  M->W pipeline register
module memory_stage #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  i_clk,
  input  logic                  i_arst,
  input  logic [2:0]            i_result_src,
  input  logic                  i_mem_we,
  input  logic                  i_reg_we,
  input  logic [2:0]            i_func3,
  input  logic [ADDR_WIDTH-1:0] i_pc_plus4,
  input  logic [ADDR_WIDTH-1:0] i_pc_target,
  input  logic [DATA_WIDTH-1:0] i_imm_ext,
  input  logic [DATA_WIDTH-1:0] i_alu_result,
  input  logic [DATA_WIDTH-1:0] i_write_data,
  input  logic [REG_ADDR_W-1:0] i_rd_addr,
  memory_stage_if.master        dmem,
  output logic                  o_stall_m,
  output logic                  o_misaligned,
  output logic [REG_ADDR_W-1:0] o_rd_addr_m,
  output logic                  o_reg_we_m,
  output logic [2:0]            o_result_src,
  output logic                  o_reg_we,
  output logic [ADDR_WIDTH-1:0] o_pc_plus4,
  output logic [ADDR_WIDTH-1:0] o_pc_target,
  output logic [DATA_WIDTH-1:0] o_imm_ext,
  output logic [DATA_WIDTH-1:0] o_alu_result,
  output logic [DATA_WIDTH-1:0] o_read_data,
  output logic [REG_ADDR_W-1:0] o_rd_addr
);
  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int OFF_W = $clog2(BE_W);

  typedef enum logic {S_IDLE, S_WAIT} state_t;
  state_t state, state_nxt;

  // ---------------- decode of the incoming access ----------------
  logic             access, legal, align_ok;
  logic [OFF_W-1:0] off_in;
  logic [BE_W-1:0]  mask_in;

  assign access = i_mem_we | (i_result_src == 3'd1);
  assign off_in = i_alu_result[OFF_W-1:0];

  always_comb begin
    mask_in  = '1;
    align_ok = (off_in == '0);
    case (i_func3[1:0])
      2'd0: begin mask_in = BE_W'(1);  align_ok = 1'b1;               end
      2'd1: begin mask_in = BE_W'(3);  align_ok = (off_in[0] == 1'b0);  end
      2'd2: begin mask_in = BE_W'(15); align_ok = (off_in[1:0] == 2'b0); end
      default: ;
    endcase
  end

  // Stores have no unsigned variants; loads have no func3=7 encoding.
  assign legal = align_ok & (i_mem_we ? ~i_func3[2] : (i_func3 != 3'd7));

  // ---------------- request registers (held across WAIT) ----------------
  logic                  rq_we;
  logic [ADDR_WIDTH-1:0] rq_addr;
  logic [DATA_WIDTH-1:0] rq_wdata;
  logic [BE_W-1:0]       rq_be;
  logic [2:0]            rq_func3;
  logic [OFF_W-1:0]      rq_off;

  // Current transaction view: live inputs in IDLE, captured copy in WAIT.
  logic                  req_raw, mis_raw, cur_we;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [DATA_WIDTH-1:0] cur_wdata;
  logic [BE_W-1:0]       cur_be;
  logic [2:0]            cur_func3;
  logic [OFF_W-1:0]      cur_off;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge i_clk or negedge i_arst) begin
    if (!i_arst) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (access && legal && !dmem.ack) state_nxt = S_WAIT;
      S_WAIT: if (dmem.ack) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    req_raw   = 1'b0;
    mis_raw   = 1'b0;
    cur_we    = 1'b0;
    cur_addr  = '0;
    cur_wdata = '0;
    cur_be    = '0;
    cur_func3 = '0;
    cur_off   = '0;
    case (state)
      S_IDLE: begin
        if (access) begin
          req_raw   = legal;
          mis_raw   = ~legal;
          cur_we    = i_mem_we;
          cur_addr  = i_alu_result[ADDR_WIDTH-1:0] & ~ADDR_WIDTH'(BE_W - 1);
          cur_wdata = i_write_data << {off_in, 3'b000};
          cur_be    = mask_in << off_in;
          cur_func3 = i_func3;
          cur_off   = off_in;
        end
      end
      S_WAIT: begin
        req_raw   = 1'b1;
        cur_we    = rq_we;
        cur_addr  = rq_addr;
        cur_wdata = rq_wdata;
        cur_be    = rq_be;
        cur_func3 = rq_func3;
        cur_off   = rq_off;
      end
      default: ;
    endcase
  end

  // Reset gates the combinational request path so req/stall drop the instant reset asserts,
  // even while the still-frozen execute register presents an access.
  assign dmem.req     = i_arst & req_raw;
  assign dmem.we      = cur_we;
  assign dmem.addr    = cur_addr;
  assign dmem.wdata   = cur_wdata;
  assign dmem.be      = cur_be;
  assign o_stall_m    = dmem.req & ~dmem.ack;
  assign o_misaligned = i_arst & mis_raw;
  assign o_rd_addr_m  = i_rd_addr;
  assign o_reg_we_m   = i_reg_we;

  always_ff @(posedge i_clk or negedge i_arst) begin
    if (!i_arst) begin
      rq_we    <= 1'b0;
      rq_addr  <= '0;
      rq_wdata <= '0;
      rq_be    <= '0;
      rq_func3 <= '0;
      rq_off   <= '0;
    end else if (state == S_IDLE && dmem.req && !dmem.ack) begin
      rq_we    <= cur_we;
      rq_addr  <= cur_addr;
      rq_wdata <= cur_wdata;
      rq_be    <= cur_be;
      rq_func3 <= cur_func3;
      rq_off   <= cur_off;
    end
  end

  // ---------------- load extraction ----------------
  logic [DATA_WIDTH-1:0] shifted, load_val;
  assign shifted = dmem.rdata >> {cur_off, 3'b000};

  always_comb begin
    load_val = '0;
    case (cur_func3)
      3'd0: load_val = {{(DATA_WIDTH-8){shifted[7]}},   shifted[7:0]};
      3'd1: load_val = {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
      3'd2: load_val = {{(DATA_WIDTH-32){shifted[31]}}, shifted[31:0]};
      3'd3: load_val = shifted;
      3'd4: load_val = {{(DATA_WIDTH-8){1'b0}},  shifted[7:0]};
      3'd5: load_val = {{(DATA_WIDTH-16){1'b0}}, shifted[15:0]};
      3'd6: load_val = {{(DATA_WIDTH-32){1'b0}}, shifted[31:0]};
      default: load_val = '0;
    endcase
  end

  // ---------------- M->W pipeline register ----------------
  // A bubble is inserted on every stalled or dropped cycle, so each instruction writes W once.
  always_ff @(posedge i_clk or negedge i_arst) begin
    if (!i_arst) begin
      o_result_src <= '0;
      o_reg_we     <= 1'b0;
      o_pc_plus4   <= '0;
      o_pc_target  <= '0;
      o_imm_ext    <= '0;
      o_alu_result <= '0;
      o_read_data  <= '0;
      o_rd_addr    <= '0;
    end else if (o_stall_m || o_misaligned) begin
      o_result_src <= '0;
      o_reg_we     <= 1'b0;
      o_pc_plus4   <= '0;
      o_pc_target  <= '0;
      o_imm_ext    <= '0;
      o_alu_result <= '0;
      o_read_data  <= '0;
      o_rd_addr    <= '0;
    end else begin
      o_result_src <= i_result_src;
      o_reg_we     <= i_reg_we;
      o_pc_plus4   <= i_pc_plus4;
      o_pc_target  <= i_pc_target;
      o_imm_ext    <= i_imm_ext;
      o_alu_result <= i_alu_result;
      o_read_data  <= (dmem.req && !cur_we) ? load_val : '0;
      o_rd_addr    <= i_rd_addr;
    end
  end
endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: directed scenarios plus a randomized run
// compared against a byte-level reference model of the load/store rules.
module tb_memory_stage;
  logic        i_clk = 1'b0;
  logic        i_arst = 1'b0;
  logic [2:0]  i_result_src = '0;
  logic        i_mem_we = 1'b0, i_reg_we = 1'b0;
  logic [2:0]  i_func3 = '0;
  logic [63:0] i_pc_plus4 = '0, i_pc_target = '0, i_imm_ext = '0;
  logic [63:0] i_alu_result = '0, i_write_data = '0;
  logic [4:0]  i_rd_addr = '0;
  logic        ack = 1'b0;
  logic [63:0] rdata = '0;
  logic        o_stall_m, o_misaligned, o_reg_we_m, o_reg_we;
  logic [4:0]  o_rd_addr_m, o_rd_addr;
  logic [2:0]  o_result_src;
  logic [63:0] o_pc_plus4, o_pc_target, o_imm_ext, o_alu_result, o_read_data;

  int checks = 0;
  int failures = 0;

  always #5 i_clk = ~i_clk;

  memory_stage_if #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) dmem ();
  assign dmem.ack   = ack;
  assign dmem.rdata = rdata;

  memory_stage #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .REG_ADDR_W(5)) dut (
    .i_clk(i_clk), .i_arst(i_arst), .i_result_src(i_result_src), .i_mem_we(i_mem_we),
    .i_reg_we(i_reg_we), .i_func3(i_func3), .i_pc_plus4(i_pc_plus4), .i_pc_target(i_pc_target),
    .i_imm_ext(i_imm_ext), .i_alu_result(i_alu_result), .i_write_data(i_write_data),
    .i_rd_addr(i_rd_addr), .dmem(dmem), .o_stall_m(o_stall_m), .o_misaligned(o_misaligned),
    .o_rd_addr_m(o_rd_addr_m), .o_reg_we_m(o_reg_we_m), .o_result_src(o_result_src),
    .o_reg_we(o_reg_we), .o_pc_plus4(o_pc_plus4), .o_pc_target(o_pc_target),
    .o_imm_ext(o_imm_ext), .o_alu_result(o_alu_result), .o_read_data(o_read_data),
    .o_rd_addr(o_rd_addr)
  );

  // ---------------- reference model ----------------
  function automatic int nbytes(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic ref_legal(input logic mw, input logic [2:0] f3, input int off);
    if ((off % nbytes(f3)) != 0) return 1'b0;
    return mw ? !f3[2] : (f3 != 3'd7);
  endfunction

  function automatic logic [7:0] ref_be(input logic [2:0] f3, input int off);
    logic [7:0] be = '0;
    for (int i = 0; i < nbytes(f3); i++) be[off + i] = 1'b1;
    return be;
  endfunction

  function automatic logic [63:0] ref_wdata(input logic [63:0] wd, input int off);
    logic [63:0] v = '0;
    for (int i = 0; i + off < 8; i++) v[8*(i+off) +: 8] = wd[8*i +: 8];
    return v;
  endfunction

  // Gather the addressed bytes, then fill the upper bytes with the sign or zeros.
  function automatic logic [63:0] ref_load(input logic [63:0] rd, input logic [2:0] f3, input int off);
    logic [63:0] v = '0;
    int n = nbytes(f3);
    for (int i = 0; i < n; i++) v[8*i +: 8] = rd[8*(off+i) +: 8];
    if (!f3[2] && n < 8 && v[8*n-1])
      for (int i = n; i < 8; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  task automatic drive(input logic [2:0] rs, input logic mw, input logic [2:0] f3,
                       input logic [63:0] addr, input logic [63:0] wd, input logic rwe,
                       input logic [4:0] rd, input logic [63:0] pc);
    i_result_src = rs; i_mem_we = mw; i_func3 = f3; i_alu_result = addr;
    i_write_data = wd; i_reg_we = rwe; i_rd_addr = rd;
    i_pc_plus4 = pc + 64'd4; i_pc_target = pc + 64'h100; i_imm_ext = pc ^ 64'h55;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    i_arst = 1'b0;
    drive(3'd1, 1'b0, 3'd3, 64'h2000, 64'h0, 1'b1, 5'd3, 64'h40);
    #3;
    checks++; if (dmem.req !== 1'b0) begin failures++; $display("FAIL reset_req got=%0b exp=0", dmem.req); end
    checks++; if (o_stall_m !== 1'b0) begin failures++; $display("FAIL reset_stall got=%0b exp=0", o_stall_m); end
    checks++; if ({o_reg_we, o_result_src, o_alu_result, o_read_data, o_pc_plus4, o_rd_addr} !== '0) begin
      failures++; $display("FAIL reset_wpreg got_we=%0b alu=%0h rd=%0h exp=0", o_reg_we, o_alu_result, o_read_data); end
    @(negedge i_clk);
    drive(3'd0, 1'b0, 3'd0, 64'h0, 64'h0, 1'b0, 5'd0, 64'h0);
    i_arst = 1'b1;
  endtask

  task automatic test_sb();
    @(negedge i_clk);
    drive(3'd0, 1'b1, 3'd0, 64'h1003, 64'hAB, 1'b0, 5'd7, 64'h80); ack = 1'b1;
    #1;
    checks++; if (dmem.req !== 1'b1 || dmem.we !== 1'b1) begin failures++; $display("FAIL sb_req got=%0b/%0b exp=1/1", dmem.req, dmem.we); end
    checks++; if (dmem.be !== 8'h08) begin failures++; $display("FAIL sb_be got=%0h exp=08", dmem.be); end
    checks++; if (dmem.wdata[31:24] !== 8'hAB) begin failures++; $display("FAIL sb_wdata got=%0h exp=ab", dmem.wdata[31:24]); end
    checks++; if (dmem.addr !== 64'h1000) begin failures++; $display("FAIL sb_addr got=%0h exp=1000", dmem.addr); end
    checks++; if (o_stall_m !== 1'b0) begin failures++; $display("FAIL sb_stall got=%0b exp=0", o_stall_m); end
    @(posedge i_clk); #1;
    checks++; if (o_alu_result !== 64'h1003 || o_read_data !== 64'h0 || o_rd_addr !== 5'd7) begin
      failures++; $display("FAIL sb_w got alu=%0h rd=%0h exp alu=1003 rd=0", o_alu_result, o_read_data); end
  endtask

  task automatic test_lh();
    @(negedge i_clk);
    drive(3'd1, 1'b0, 3'd1, 64'h1006, 64'h0, 1'b1, 5'd9, 64'h84);
    rdata = 64'h8001_0000_0000_0000; ack = 1'b1;
    #1;
    checks++; if (dmem.req !== 1'b1 || dmem.be !== 8'hC0 || o_stall_m !== 1'b0) begin
      failures++; $display("FAIL lh_req got req=%0b be=%0h stall=%0b exp 1/c0/0", dmem.req, dmem.be, o_stall_m); end
    @(posedge i_clk); #1;
    checks++; if (o_read_data !== 64'hFFFF_FFFF_FFFF_8001) begin failures++; $display("FAIL lh_data got=%0h exp=ffffffffffff8001", o_read_data); end
    checks++; if (o_reg_we !== 1'b1 || o_result_src !== 3'd1) begin failures++; $display("FAIL lh_ctl got=%0b/%0d exp=1/1", o_reg_we, o_result_src); end
  endtask

  task automatic test_wait();
    int stalls = 0, writes = 0;
    logic [63:0] got = '0;
    @(negedge i_clk);
    drive(3'd1, 1'b0, 3'd6, 64'h1004, 64'h0, 1'b1, 5'd11, 64'h88);
    rdata = 64'h9234_5678_0000_0000; ack = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++; if (dmem.req !== 1'b1 || dmem.addr !== 64'h1000 || dmem.be !== 8'hF0) begin
        failures++; $display("FAIL wait_stable c=%0d got req=%0b addr=%0h be=%0h exp 1/1000/f0", c, dmem.req, dmem.addr, dmem.be); end
      if (o_stall_m) stalls++;
      @(posedge i_clk); #1;
      if (o_reg_we) begin writes++; got = o_read_data; end
      @(negedge i_clk);
      ack = (c + 1 == 3);
      if (c < 3) begin i_func3 = 3'd3; i_write_data = {$urandom, $urandom}; end
    end
    ack = 1'b0;
    checks++; if (stalls !== 3) begin failures++; $display("FAIL wait_stalls got=%0d exp=3", stalls); end
    checks++; if (writes !== 1) begin failures++; $display("FAIL wait_writes got=%0d exp=1", writes); end
    checks++; if (got !== 64'h0000_0000_9234_5678) begin failures++; $display("FAIL wait_data got=%0h exp=92345678", got); end
    drive(3'd0, 1'b0, 3'd0, 64'h5, 64'h0, 1'b1, 5'd1, 64'h8C);
    #1;
    checks++; if (dmem.req !== 1'b0 || o_stall_m !== 1'b0) begin failures++; $display("FAIL wait_idle got req=%0b stall=%0b exp 0/0", dmem.req, o_stall_m); end
    @(posedge i_clk); #1;
  endtask

  task automatic test_misaligned();
    @(negedge i_clk);
    drive(3'd1, 1'b0, 3'd2, 64'h1002, 64'h0, 1'b1, 5'd12, 64'h90); ack = 1'b0;
    #1;
    checks++; if (dmem.req !== 1'b0 || o_misaligned !== 1'b1 || o_stall_m !== 1'b0) begin
      failures++; $display("FAIL mis_pulse got req=%0b mis=%0b stall=%0b exp 0/1/0", dmem.req, o_misaligned, o_stall_m); end
    @(posedge i_clk); #1;
    checks++; if (o_reg_we !== 1'b0) begin failures++; $display("FAIL mis_bubble got=%0b exp=0", o_reg_we); end
    @(negedge i_clk);
    drive(3'd0, 1'b0, 3'd0, 64'h7, 64'h0, 1'b1, 5'd2, 64'h94);
    #1;
    checks++; if (o_misaligned !== 1'b0) begin failures++; $display("FAIL mis_once got=%0b exp=0", o_misaligned); end
    @(posedge i_clk); #1;
  endtask

  task automatic test_reset_in_wait();
    @(negedge i_clk);
    drive(3'd1, 1'b0, 3'd3, 64'h2000, 64'h0, 1'b1, 5'd4, 64'hA0); ack = 1'b0;
    #1;
    checks++; if (dmem.req !== 1'b1 || o_stall_m !== 1'b1) begin failures++; $display("FAIL rw_start got req=%0b stall=%0b exp 1/1", dmem.req, o_stall_m); end
    @(posedge i_clk); #2;
    i_arst = 1'b0;
    #1;
    checks++; if (dmem.req !== 1'b0 || o_stall_m !== 1'b0 || o_misaligned !== 1'b0) begin
      failures++; $display("FAIL rw_drop got req=%0b stall=%0b mis=%0b exp 0/0/0", dmem.req, o_stall_m, o_misaligned); end
    @(negedge i_clk);
    i_arst = 1'b1;
    drive(3'd0, 1'b0, 3'd0, 64'h0, 64'h0, 1'b0, 5'd0, 64'h0);
    ack = 1'b1; rdata = 64'hFFFF_0000_FFFF_0000;
    #1;
    checks++; if (dmem.req !== 1'b0 || o_stall_m !== 1'b0) begin failures++; $display("FAIL rw_late_ack got req=%0b stall=%0b exp 0/0", dmem.req, o_stall_m); end
    @(posedge i_clk); #1;
    checks++; if (o_reg_we !== 1'b0 || o_read_data !== 64'h0 || o_alu_result !== 64'h0 || o_result_src !== 3'd0) begin
      failures++; $display("FAIL rw_w got we=%0b rd=%0h alu=%0h exp 0", o_reg_we, o_read_data, o_alu_result); end
    ack = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [2:0]  rs [3]  = '{3'd1, 3'd0, 3'd0};
    logic        mw [3]  = '{1'b0, 1'b1, 1'b0};
    logic [2:0]  f3 [3]  = '{3'd3, 3'd3, 3'd0};
    logic [63:0] ad [3]  = '{64'h3000, 64'h3008, 64'h1234};
    logic        rwe [3] = '{1'b1, 1'b0, 1'b1};
    logic [63:0] rdv = 64'hCAFE_F00D_1234_5678;
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      drive(rs[i], mw[i], f3[i], ad[i], 64'h1111_2222_3333_4444, rwe[i], 5'(20 + i), 64'h200 + 64'(4*i));
      rdata = rdv; ack = 1'b1;
      #1;
      checks++; if (o_stall_m !== 1'b0) begin failures++; $display("FAIL b2b_stall i=%0d got=%0b exp=0", i, o_stall_m); end
      @(posedge i_clk); #1;
      checks++; if (o_alu_result !== ad[i] || o_reg_we !== rwe[i] || o_rd_addr !== 5'(20 + i) ||
                    o_read_data !== ((i == 0) ? rdv : 64'h0)) begin
        failures++; $display("FAIL b2b_w i=%0d got alu=%0h we=%0b data=%0h exp alu=%0h we=%0b", i, o_alu_result, o_reg_we, o_read_data, ad[i], rwe[i]); end
    end
    ack = 1'b0;
  endtask

  task automatic test_random();
    for (int it = 0; it < 60; it++) begin
      int kind = $urandom_range(0, 2);
      logic [2:0] rs = 3'd0, f3 = 3'($urandom_range(0, 7));
      logic mw = 1'b0, rwe = 1'b1, acc, leg;
      int off, d;
      logic [63:0] addr, wd = {$urandom, $urandom}, rdv = {$urandom, $urandom}, pc = 64'(4 * $urandom_range(0, 4095));
      logic [4:0] rd = 5'($urandom_range(0, 31));
      if (kind == 0) rs = ($urandom_range(0, 1) != 0) ? 3'd2 : 3'd0;
      else if (kind == 1) rs = 3'd1;
      else begin mw = 1'b1; rwe = 1'b0; end
      off = $urandom_range(0, 7);
      if ($urandom_range(0, 1) != 0) off = off - (off % nbytes(f3));
      addr = 64'h1000 + 64'(8 * $urandom_range(0, 255)) + 64'(off);
      acc = (kind != 0);
      leg = acc && ref_legal(mw, f3, off);
      d = leg ? $urandom_range(0, 3) : 0;
      @(negedge i_clk);
      drive(rs, mw, f3, addr, wd, rwe, rd, pc);
      rdata = rdv;
      ack = leg ? (d == 0) : 1'($urandom_range(0, 1));
      #1;
      checks++; if (dmem.req !== leg || o_misaligned !== (acc && !leg) || o_stall_m !== (leg && d > 0)) begin
        failures++; $display("FAIL rnd_req it=%0d got req=%0b mis=%0b stall=%0b exp %0b/%0b/%0b", it, dmem.req, o_misaligned, o_stall_m, leg, acc && !leg, leg && d > 0); end
      if (leg) begin
        checks++; if (dmem.addr !== (addr & ~64'h7) || dmem.be !== ref_be(f3, off) || dmem.we !== mw ||
                      (mw && dmem.wdata !== ref_wdata(wd, off))) begin
          failures++; $display("FAIL rnd_bus it=%0d got addr=%0h be=%0h we=%0b wd=%0h exp addr=%0h be=%0h", it, dmem.addr, dmem.be, dmem.we, dmem.wdata, addr & ~64'h7, ref_be(f3, off)); end
      end
      for (int k = 1; k <= d; k++) begin
        @(posedge i_clk); #1;
        checks++; if (o_reg_we !== 1'b0) begin failures++; $display("FAIL rnd_bubble it=%0d got=%0b exp=0", it, o_reg_we); end
        @(negedge i_clk);
        ack = (k == d);
        i_write_data = {$urandom, $urandom}; i_func3 = 3'($urandom_range(0, 7));
        #1;
        checks++; if (dmem.req !== 1'b1 || dmem.be !== ref_be(f3, off) || o_stall_m !== (k != d) ||
                      (mw && dmem.wdata !== ref_wdata(wd, off))) begin
          failures++; $display("FAIL rnd_hold it=%0d k=%0d got req=%0b be=%0h stall=%0b", it, k, dmem.req, dmem.be, o_stall_m); end
      end
      @(posedge i_clk); #1;
      if (acc && !leg) begin
        checks++; if (o_reg_we !== 1'b0) begin failures++; $display("FAIL rnd_drop it=%0d got=%0b exp=0", it, o_reg_we); end
      end else begin
        checks++; if (o_reg_we !== rwe || o_result_src !== rs || o_alu_result !== addr || o_rd_addr !== rd ||
                      o_pc_plus4 !== pc + 64'd4 ||
                      o_read_data !== ((kind == 1) ? ref_load(rdv, f3, off) : 64'h0)) begin
          failures++; $display("FAIL rnd_w it=%0d got we=%0b src=%0d alu=%0h data=%0h exp we=%0b data=%0h", it, o_reg_we, o_result_src, o_alu_result, o_read_data, rwe, (kind == 1) ? ref_load(rdv, f3, off) : 64'h0); end
      end
    end
    ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sb();
    test_lh();
    test_wait();
    test_misaligned();
    test_reset_in_wait();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
